// File: rtl/bw_pixel_unpacker.sv
// rtl/bw_pixel_unpacker.sv - serialises 1bpp image RAM bytes into a pixel stream with row/frame markers
module bw_pixel_unpacker #(
    parameter int ADDR_W    = 9,
    parameter int BASE_ADDR = 0,
    parameter int NUM_BYTES = 512,
    parameter int IMG_W     = 160,
    parameter int LOOP      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    input  logic              rd_valid,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_data,
    output logic              pix_eol,
    output logic              pix_sof,
    output logic              pix_last,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int X_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [CNT_W-1:0] NB       = CNT_W'(NUM_BYTES);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(IMG_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_WAIT, S_SHIFT} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] req_idx, out_idx;
    logic [X_W-1:0]   x;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg, nbuf;
    logic             nb_valid, rd_pend, frame_done_r;

    logic rd_hit, in_shift, accept, byte_end, frame_end, prefetch;

    // rd_pend gates rd_valid so a read issued before reset cannot land afterwards
    assign rd_hit    = rd_valid & rd_pend;
    assign in_shift  = (state == S_SHIFT);
    assign accept    = in_shift & pix_ready;
    assign byte_end  = accept & (bit_idx == 3'd7);
    assign frame_end = byte_end & (out_idx == LAST_IDX);
    assign prefetch  = in_shift & ~nb_valid & ~rd_pend & (req_idx < NB);

    assign rd_en   = (state == S_FILL) | prefetch;
    assign rd_addr = rd_en ? (ADDR_W'(BASE_ADDR) + req_idx[ADDR_W-1:0]) : '0;

    assign pix_valid  = in_shift;
    assign pix_data   = in_shift & shreg[7];
    assign pix_eol    = in_shift & (x == X_LAST);
    assign pix_sof    = in_shift & (out_idx == '0) & (bit_idx == 3'd0);
    assign pix_last   = in_shift & (out_idx == LAST_IDX) & (bit_idx == 3'd7);
    assign busy       = (state != S_IDLE);
    assign frame_done = frame_done_r;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_FILL;
            S_FILL:  state_nx = S_WAIT;
            S_WAIT:  if (rd_hit) state_nx = S_SHIFT;
            S_SHIFT: begin
                if (frame_end)
                    state_nx = (LOOP != 0) ? S_FILL : S_IDLE;
                else if (byte_end && !nb_valid && !rd_hit)
                    state_nx = rd_pend ? S_WAIT : S_FILL;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            req_idx      <= '0;
            out_idx      <= '0;
            x            <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            nbuf         <= '0;
            nb_valid     <= 1'b0;
            rd_pend      <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state        <= state_nx;
            frame_done_r <= frame_end;
            rd_pend      <= rd_en;
            if (rd_en)
                req_idx <= req_idx + 1'b1;
            case (state)
                S_IDLE: if (start) begin
                    req_idx  <= '0;
                    out_idx  <= '0;
                    x        <= '0;
                    nb_valid <= 1'b0;
                end
                S_WAIT: if (rd_hit) begin
                    shreg   <= rd_data;
                    bit_idx <= 3'd0;
                end
                S_SHIFT: begin
                    if (rd_hit) begin
                        nbuf     <= rd_data;
                        nb_valid <= 1'b1;
                    end
                    if (accept) begin
                        x <= (x == X_LAST) ? '0 : x + 1'b1;
                        if (bit_idx != 3'd7) begin
                            shreg   <= {shreg[6:0], 1'b0};
                            bit_idx <= bit_idx + 1'b1;
                        end else if (frame_end) begin
                            req_idx  <= '0;
                            out_idx  <= '0;
                            x        <= '0;
                            nb_valid <= 1'b0;
                        end else if (nb_valid) begin
                            shreg    <= nbuf;
                            nb_valid <= 1'b0;
                            bit_idx  <= 3'd0;
                            out_idx  <= out_idx + 1'b1;
                        end else if (rd_hit) begin
                            // data arriving this cycle bypasses the empty prefetch buffer
                            shreg    <= rd_data;
                            nb_valid <= 1'b0;
                            bit_idx  <= 3'd0;
                            out_idx  <= out_idx + 1'b1;
                        end else begin
                            out_idx <= out_idx + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bw_pixel_unpacker.sv
// tb/tb_bw_pixel_unpacker.sv - self-checking bench for bw_pixel_unpacker
module tb_bw_pixel_unpacker;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, pix_ready;
    logic       rd_en, rd_valid, pix_valid, pix_data, pix_eol, pix_sof, pix_last, busy, frame_done;
    logic [8:0] rd_addr;
    logic [7:0] rd_data;

    logic       start_l, pix_ready_l;
    logic       rd_en_l, rd_valid_l, pix_valid_l, pix_data_l, pix_eol_l, pix_sof_l, pix_last_l, busy_l, frame_done_l;
    logic [8:0] rd_addr_l;
    logic [7:0] rd_data_l;

    logic [7:0] mem [512];

    bw_pixel_unpacker dut (
        .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_eol(pix_eol), .pix_sof(pix_sof), .pix_last(pix_last),
        .busy(busy), .frame_done(frame_done)
    );

    bw_pixel_unpacker #(.NUM_BYTES(4), .LOOP(1)) dut_loop (
        .clk(clk), .rst(rst), .start(start_l), .rd_en(rd_en_l), .rd_addr(rd_addr_l),
        .rd_data(rd_data_l), .rd_valid(rd_valid_l), .pix_valid(pix_valid_l), .pix_ready(pix_ready_l),
        .pix_data(pix_data_l), .pix_eol(pix_eol_l), .pix_sof(pix_sof_l), .pix_last(pix_last_l),
        .busy(busy_l), .frame_done(frame_done_l)
    );

    // RAM models with a fixed one-cycle read latency
    always @(posedge clk) begin
        rd_valid   <= rd_en;
        rd_valid_l <= rd_en_l;
        if (rd_en)   rd_data   <= mem[rd_addr];
        if (rd_en_l) rd_data_l <= mem[rd_addr_l];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct packed {logic data; logic sof; logic eol; logic last;} pix_t;
    typedef struct {int idx; pix_t exp;} vec_t;

    pix_t cur;
    assign cur = '{data: pix_data, sof: pix_sof, eol: pix_eol, last: pix_last};

    pix_t pix_q[$];
    int   acc_cyc[$];
    int   addr_q[$];
    int   fd_cyc[$];
    int   dbl_rd, unstable;
    logic p_en, p_stall;
    pix_t p_pix;

    always @(negedge clk) begin
        if (rst) begin
            p_en    = 1'b0;
            p_stall = 1'b0;
        end else begin
            if (rd_en) begin
                addr_q.push_back(int'(rd_addr));
                if (p_en) dbl_rd++;
            end
            if (p_stall && (!pix_valid || cur != p_pix)) unstable++;
            if (pix_valid && pix_ready) begin
                pix_q.push_back(cur);
                acc_cyc.push_back(cyc);
            end
            if (frame_done) fd_cyc.push_back(cyc);
            p_en    = rd_en;
            p_stall = pix_valid && !pix_ready;
            p_pix   = cur;
        end
    end

    int l_acc = 0;
    int l_addr[$];
    int l_fd_acc[$];
    int l_sof_acc[$];

    always @(negedge clk) begin
        if (!rst && l_acc < 200) begin
            if (rd_en_l) l_addr.push_back(int'(rd_addr_l));
            if (frame_done_l) l_fd_acc.push_back(l_acc);
            if (pix_valid_l && pix_ready_l) begin
                if (pix_sof_l) l_sof_acc.push_back(l_acc);
                l_acc++;
            end
        end
    end

    vec_t vecs[22];

    task automatic clear_mon();
        pix_q.delete();
        acc_cyc.delete();
        addr_q.delete();
        fd_cyc.delete();
        dbl_rd   = 0;
        unstable = 0;
    endtask

    task automatic run_frame(input int stall_pct, input bit extra_start, output int start_c);
        clear_mon();
        pix_ready = 1'b1;
        @(posedge clk); #2;
        start   = 1'b1;
        start_c = cyc;
        @(posedge clk); #2;
        start = 1'b0;
        for (int n = 0; n < 8000 && fd_cyc.size() == 0; n++) begin
            pix_ready = ($urandom_range(0, 99) >= stall_pct);
            start     = extra_start && (n == 100);
            @(posedge clk); #2;
        end
        start     = 1'b0;
        pix_ready = 1'b1;
        chk("frame_completed", fd_cyc.size(), 1);
    endtask

    task automatic check_vectors(input string tag);
        for (int i = 0; i < 22; i++) begin
            if (vecs[i].idx < pix_q.size())
                chk($sformatf("%s_vec_pix%0d", tag, vecs[i].idx), int'(pix_q[vecs[i].idx]), int'(vecs[i].exp));
            else
                chk($sformatf("%s_vec_pix%0d_missing", tag, vecs[i].idx), pix_q.size(), vecs[i].idx + 1);
        end
    endtask

    task automatic check_frame(input string tag, input bit no_gaps, input int start_c);
        int bad_addr, bad_data, bad_sof, bad_eol, bad_last, gaps, eols;
        logic [7:0] b;
        bad_addr = 0; bad_data = 0; bad_sof = 0; bad_eol = 0; bad_last = 0; gaps = 0; eols = 0;
        chk({tag, "_pixel_count"}, pix_q.size(), 4096);
        chk({tag, "_read_count"}, addr_q.size(), 512);
        foreach (addr_q[i]) if (addr_q[i] != i) bad_addr++;
        chk({tag, "_addr_seq"}, bad_addr, 0);
        foreach (pix_q[i]) begin
            b = mem[i / 8];
            if (pix_q[i].data != b[7 - (i % 8)])      bad_data++;
            if (pix_q[i].sof  != (i == 0))            bad_sof++;
            if (pix_q[i].eol  != ((i % 160) == 159))  bad_eol++;
            if (pix_q[i].last != (i == 4095))         bad_last++;
            if (pix_q[i].eol) eols++;
            if (i > 0 && acc_cyc[i] != acc_cyc[i-1] + 1) gaps++;
        end
        chk({tag, "_data"}, bad_data, 0);
        chk({tag, "_sof"}, bad_sof, 0);
        chk({tag, "_eol"}, bad_eol, 0);
        chk({tag, "_eol_count"}, eols, 25);
        chk({tag, "_last"}, bad_last, 0);
        if (fd_cyc.size() > 0 && acc_cyc.size() > 0)
            chk({tag, "_frame_done_latency"}, fd_cyc[0] - acc_cyc[acc_cyc.size()-1], 1);
        chk({tag, "_busy_after"}, int'(busy), 0);
        chk({tag, "_double_read"}, dbl_rd, 0);
        chk({tag, "_stall_unstable"}, unstable, 0);
        if (no_gaps) begin
            chk({tag, "_gaps"}, gaps, 0);
            if (acc_cyc.size() > 0)
                chk({tag, "_first_latency"}, acc_cyc[0] - start_c, 3);
        end
    endtask

    initial begin
        logic [15:0] head;
        int sc, bad;

        for (int i = 0; i < 512; i++) mem[i] = 8'(i * 37 + 5);
        mem[0] = 8'h01;
        mem[1] = 8'hFC;

        head = 16'b0000_0001_1111_1100;
        for (int i = 0; i < 16; i++) vecs[i] = '{i, pix_t'({head[15 - i], i == 0, 1'b0, 1'b0})};
        vecs[16] = '{159,  4'b0010};
        vecs[17] = '{160,  4'b1000};
        vecs[18] = '{319,  4'b0010};
        vecs[19] = '{4088, 4'b1000};
        vecs[20] = '{4094, 4'b0000};
        vecs[21] = '{4095, 4'b0001};

        rst = 1'b1; start = 1'b0; pix_ready = 1'b1; start_l = 1'b0; pix_ready_l = 1'b1;
        #1;
        chk("reset_outputs", int'({rd_en, rd_addr, pix_valid, pix_data, pix_eol, pix_sof, pix_last, busy, frame_done}), 0);
        chk("reset_outputs_loop", int'({rd_en_l, rd_addr_l, pix_valid_l, busy_l, frame_done_l}), 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        @(posedge clk); #2 start_l = 1'b1;
        @(posedge clk); #2 start_l = 1'b0;

        // Frame A: sink always ready
        run_frame(0, 1'b0, sc);
        check_vectors("A");
        check_frame("A", 1'b1, sc);

        // LOOP instance has been free-running alongside frame A
        chk("loop_fd_count_min", int'(l_fd_acc.size() >= 5), 1);
        bad = 0;
        foreach (l_fd_acc[k]) if (l_fd_acc[k] != 32 * (k + 1)) bad++;
        chk("loop_fd_spacing", bad, 0);
        bad = 0;
        foreach (l_sof_acc[k]) if (l_sof_acc[k] != 32 * k) bad++;
        chk("loop_sof_positions", bad, 0);
        chk("loop_sof_count_min", int'(l_sof_acc.size() >= 6), 1);
        bad = 0;
        for (int k = 0; k < 12; k++) if (k >= l_addr.size() || l_addr[k] != (k % 4)) bad++;
        chk("loop_addr_seq", bad, 0);

        // Frame B: 30% backpressure plus a start pulse while busy
        run_frame(30, 1'b1, sc);
        check_vectors("B");
        check_frame("B", 1'b0, sc);

        // Reset while pixel 43 (byte 5, bit 3) is presented
        clear_mon();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        for (int n = 0; n < 200 && pix_q.size() < 43; n++) begin
            @(posedge clk); #2;
        end
        chk("rst_reached_pixel43", pix_q.size(), 43);
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", int'({rd_en, rd_addr, pix_valid, pix_data, pix_eol, pix_sof, pix_last, busy, frame_done}), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        clear_mon();
        repeat (10) @(posedge clk);
        #2;
        chk("rst_no_reads_until_start", addr_q.size(), 0);
        chk("rst_idle_after", int'(busy), 0);

        // Frame D: restart after reset begins at BASE_ADDR
        run_frame(0, 1'b0, sc);
        check_vectors("D");
        check_frame("D", 1'b1, sc);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
